// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
// ------------------
// Shares the register file's single write port among NREQ writeback sources
// (ALU, LSU, MUL/CSR). It grants one requester per cycle and registers the
// winner into an output stage. That stage drives the register file's
// we/waddr/wdata directly, so a granted write lands one cycle after its
// handshake.
//
// Handshake: a requester raises req_valid[i] and holds addr/data stable until
// it sees req_ready[i]. The transfer happens in the cycle where
// req_valid[i] & req_ready[i]. req_ready[i] is only ever raised for a valid
// requester, and at most one bit is set at a time. There is no back-pressure
// from the register file.
//
// Arbitration:
//   default              : round-robin. The search starts at ptr and wraps
//                          modulo NREQ. After a grant to i, ptr moves to i+1.
//   WBARB_FIXED_PRIO_EN  : fixed priority. The lowest valid index wins and
//                          there is no pointer state.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   req_valid[NREQ]   per-requester write request
//   req_addr          per-requester destination, slice i = [i*ADDR_W +: ADDR_W]
//   req_data          per-requester data, slice i = [i*DATA_W +: DATA_W]
//   req_ready[NREQ]   per-requester grant
//   flush             suppresses all grants this cycle
//   rf_we/rf_waddr/rf_wdata  register file write port (registered)
//   busy              equals rf_we: a write is in flight this cycle
module regfile_wb_arbiter #(
    parameter int NREQ   = 3,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*DATA_W-1:0]   req_data,
    output logic [NREQ-1:0]          req_ready,
    input  logic                     flush,
    output logic                     rf_we,
    output logic [ADDR_W-1:0]        rf_waddr,
    output logic [DATA_W-1:0]        rf_wdata,
    output logic                     busy
);

    logic [NREQ-1:0]   grant_oh;   // one-hot winner before flush/reset gating
    logic              found;      // some requester is valid
    logic              hs;         // a transfer happens this cycle
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

`ifndef WBARB_FIXED_PRIO_EN
    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [PTR_W:0] NREQ_W = (PTR_W+1)'(NREQ);

    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] win_idx;
    logic [PTR_W:0]   idx;         // one extra bit so ptr+k never overflows

    // The rotating search starts at ptr. The wrap is done by a single
    // subtraction because ptr+k < 2*NREQ always holds.
    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        idx     = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = {1'b0, ptr} + (PTR_W+1)'(k);
            if (idx >= NREQ_W) idx = idx - NREQ_W;
            if (!found && req_valid[idx[PTR_W-1:0]]) begin
                found   = 1'b1;
                win_idx = idx[PTR_W-1:0];
            end
        end
        grant_oh = found ? (NREQ'(1) << win_idx) : '0;
    end

    // The pointer moves only on a real transfer. Flush and reset cycles
    // leave it alone, apart from the reset clear itself.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (hs) begin
            if (win_idx == PTR_W'(NREQ - 1)) ptr <= '0;
            else                             ptr <= win_idx + 1'b1;
        end
    end
`else
    // Fixed priority: the lowest valid index wins.
    always_comb begin
        found    = 1'b0;
        grant_oh = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && req_valid[k]) begin
                found       = 1'b1;
                grant_oh[k] = 1'b1;
            end
        end
    end
`endif

    assign hs        = found & ~flush & ~rst;
    assign req_ready = hs ? grant_oh : '0;

    // AND-OR mux of the winner's address and data.
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_oh[i]) begin
                sel_addr = sel_addr | req_addr[i*ADDR_W +: ADDR_W];
                sel_data = sel_data | req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Output stage. A write to x0 is accepted and loads the address and data
    // registers, but it does not raise rf_we. Without a transfer, rf_we drops
    // and the address and data registers hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else if (hs) begin
            rf_we    <= |sel_addr;
            rf_waddr <= sel_addr;
            rf_wdata <= sel_data;
        end else begin
            rf_we    <= 1'b0;
        end
    end

    assign busy = rf_we;

endmodule
